float8_mul_arbiter: RTL
=======================

# float8_mul_arbiter

Round-robin arbiter and sequencer that shares one combinational `float8_multiplication` instance among `N_REQ` requesters. It accepts one operand pair at a time over per-requester valid/ready handshakes, registers the operands, and registers the product. It then presents the product with the winning requester's index on a single valid/ready response port. It sits between the float8 operand producers (e.g. dot-product or scaling engines) and the shared multiplier datapath.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default 2: width of `rsp_id`; must satisfy 2^ID_W >= N_REQ.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `req_valid`  in  N_REQ  bit i high means requester i presents an operand pair.
- `req_a`  in  8*N_REQ  operand A of requester i, in bits [8i+7:8i]; float8 format (1 sign, 3 exponent, 4 fraction).
- `req_b`  in  8*N_REQ  operand B of requester i, in bits [8i+7:8i]; same format.
- `req_ready`  out  N_REQ  one-hot or zero; bit i high accepts requester i this cycle.
- `rsp_valid`  out  1  a product is available.
- `rsp_id`  out  ID_W  index of the requester that owns the product.
- `rsp_result`  out  8  product, exactly as returned by `float8_multiplication`.
- `rsp_ready`  in  1  the consumer accepts the response.

## Operation
- The FSM has three states: IDLE, MUL and RESP.
- IDLE:
  - If any `req_valid` bit is set, grant the lowest index at or after `rr_ptr`, wrapping modulo N_REQ.
  - `req_ready[g]` is high combinationally from `req_valid` and state; this is the only valid-to-ready path.
  - On a grant: latch `req_a[g]`, `req_b[g]` and `g` into `op_a`, `op_b` and `id_q`; set `rr_ptr <= (g+1) mod N_REQ`; go to MUL.
  - If no request is valid, stay in IDLE; `rr_ptr` does not change.
- MUL:
  - `op_a` and `op_b` drive the multiplier.
  - Its output is captured into `rsp_result`, `id_q` is copied to `rsp_id`, and the FSM goes to RESP.
  - `req_ready` is all zero.
- RESP:
  - `rsp_valid` is high.
  - `rsp_result` and `rsp_id` stay stable until `rsp_valid && rsp_ready`; on that handshake the FSM returns to IDLE.
  - `req_ready` is all zero.
- Requester rules:
  - A requester holds `req_valid`, `req_a` and `req_b` stable until it sees `req_ready` high.
  - The arbiter never grants a requester whose `req_valid` is low.
- Fairness: with all requesters continuously valid, grants go 0, 1, …, N_REQ-1, 0, … A requester waits at most N_REQ-1 transactions.
- Request pins not valid in IDLE are ignored; their operand values do not matter.
- The arbiter does not interpret the arithmetic. Sign, exponent and fraction handling, including any out-of-range exponent, is the multiplier's behaviour, passed through unmodified.

## Timing
- Reset (asynchronous, any state) sets:
  - state = IDLE, `rr_ptr` = 0;
  - `op_a`, `op_b`, `id_q`, `rsp_result` and `rsp_id` = 0;
  - `rsp_valid` = 0.
- `req_ready` is all zero while `rst` is high.
- Reset during MUL or RESP discards the transaction; no response is produced for it.
- Latency: acceptance in cycle T puts `rsp_valid` high in cycle T+2.
- With `rsp_ready` held high, `rsp_valid` is high for exactly one cycle (T+2). The earliest next acceptance is T+3, so peak throughput is one product per 3 cycles.
- Backpressure: if `rsp_ready` is low, RESP holds for any number of cycles. No request is accepted meanwhile, and `req_ready` stays zero.
- Simultaneous events:
  - `rsp_ready` may be high before `rsp_valid`; this is legal and completes the handshake in the first RESP cycle.
  - A new request arriving in the RESP handshake cycle is granted on the following cycle, in IDLE.
- Wrap-around: a grant to index N_REQ-1 sets `rr_ptr` = 0.

## Test plan
1. Single requester, `rsp_ready` = 1:
   - Requester 2 sends `a`=0x70 (1.0) and `b`=0x48 (0.1875), accepted at cycle T.
   - Expect `rsp_valid` at T+2 with `rsp_result`=0x48 and `rsp_id`=2; `rr_ptr` becomes 3.
2. All four requesters valid continuously, `rsp_ready` = 1, each sending 0xF0 × 0x48 (−1.0 × 0.1875):
   - Expect grants 0, 1, 2, 3, 0, one every 3 cycles.
   - Every response has `rsp_result`=0xC8, with `rsp_id` following the same sequence.
3. Backpressure:
   - Hold `rsp_ready`=0 for 5 cycles after `rsp_valid` rises, with requester 1 pending.
   - `rsp_result` and `rsp_id` stay stable and `req_ready`=0 throughout.
   - Requester 1 is granted the cycle after `rsp_ready` goes to 1.
4. Wrap-around:
   - With `rr_ptr`=3, requesters 0 and 3 both valid: requester 3 is granted first, then `rr_ptr`=0 and requester 0 is granted next.
5. Reset mid-operation:
   - Assert `rst` during MUL: all outputs go to 0 immediately and no `rsp_valid` follows.
   - After release, requester 0 is granted first (`rr_ptr`=0).
6. Randomized operands against a reference `float8_multiplication` instance:
   - Every `rsp_result` equals the reference product of the operands accepted for that `rsp_id`.
   - No request is lost or duplicated over 1000 transactions.

Source files
------------

// File: rtl/float8_mul_arbiter.sv
// float8_mul_arbiter: round-robin arbiter and sequencer that shares one
// combinational float8 multiplier among N_REQ requesters. One operand pair
// is in flight at a time: IDLE grants, MUL captures the product, RESP holds
// the product and owner index until the consumer takes it.
// Also contains float8_multiplication, the shared combinational datapath.

`timescale 1ns/1ps

// float8_multiplication: 1 sign, 3 exponent (bias 7), 4 fraction bits with
// an implicit leading one. The significand product is truncated and
// normalised by at most one place. The exponent is computed modulo 8, so an
// out-of-range result wraps instead of saturating. There is no special
// encoding for zero, infinity or NaN.
module float8_multiplication (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] result
);

   logic       sign_s;
   logic [4:0] man_a_s;
   logic [4:0] man_b_s;
   logic [5:0] prod_hi_s;
   logic [2:0] exp_s;
   logic [3:0] frac_s;

   // Multiply significands, normalise one place, rebias exponent modulo 8
   always_comb begin
      sign_s    = a[7] ^ b[7];
      man_a_s   = {1'b1, a[3:0]};
      man_b_s   = {1'b1, b[3:0]};
      // Bits below the fraction LSB are dropped (truncation).
      prod_hi_s = 6'(({5'd0, man_a_s} * {5'd0, man_b_s}) >> 4);
      if (prod_hi_s[5]) begin
         // Product in [2,4): shift right one place, bump exponent.
         frac_s = prod_hi_s[4:1];
         exp_s  = a[6:4] + b[6:4] + 3'd2;
      end else begin
         // Product in [1,2): already normalised. ea+eb-7 == ea+eb+1 mod 8.
         frac_s = prod_hi_s[3:0];
         exp_s  = a[6:4] + b[6:4] + 3'd1;
      end
      result = {sign_s, exp_s, frac_s};
   end

endmodule

// Arbiter / sequencer around the shared multiplier.
// N_REQ must lie in 2..8 and 2**ID_W must be >= N_REQ.
module float8_mul_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_a,
   input  logic [8*N_REQ-1:0]   req_b,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 rsp_valid,
   output logic [ID_W-1:0]      rsp_id,
   output logic [7:0]           rsp_result,
   input  logic                 rsp_ready
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          state_r;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] id_q;
   logic [7:0]      op_a;
   logic [7:0]      op_b;

   logic            grant_any_s;
   logic [ID_W-1:0] grant_idx_s;
   logic [ID_W-1:0] next_ptr_s;
   logic [7:0]      sel_a_s;
   logic [7:0]      sel_b_s;
   logic [7:0]      mul_s;

   // Round-robin pick: first valid requester at or after rr_ptr, wrapping
   always_comb begin
      logic [ID_W:0]   sum_v;
      logic [ID_W-1:0] idx_v;
      grant_any_s = 1'b0;
      grant_idx_s = {ID_W{1'b0}};
      for (int k = 0; k < N_REQ; k++) begin
         sum_v = {1'b0, rr_ptr} + (ID_W+1)'(k);
         sum_v = (sum_v >= (ID_W+1)'(N_REQ)) ? (sum_v - (ID_W+1)'(N_REQ)) : sum_v;
         idx_v = sum_v[ID_W-1:0];
         if (!grant_any_s && req_valid[idx_v]) begin
            grant_any_s = 1'b1;
            grant_idx_s = idx_v;
         end else begin
            grant_any_s = grant_any_s;
            grant_idx_s = grant_idx_s;
         end
      end
   end

   // Pointer advance past the winner, wrapping to zero after N_REQ-1
   always_comb begin
      if (grant_idx_s == ID_W'(N_REQ - 1)) begin
         next_ptr_s = {ID_W{1'b0}};
      end else begin
         next_ptr_s = grant_idx_s + ID_W'(1);
      end
   end

   // Operand mux for the winning requester
   always_comb begin
      sel_a_s = req_a[{grant_idx_s, 3'b000} +: 8];
      sel_b_s = req_b[{grant_idx_s, 3'b000} +: 8];
   end

   // Ready is the only valid-to-ready path: one-hot in IDLE, zero otherwise
   always_comb begin
      req_ready = {N_REQ{1'b0}};
      if (!rst && (state_r == ST_IDLE) && grant_any_s) begin
         req_ready[grant_idx_s] = 1'b1;
      end else begin
         req_ready = {N_REQ{1'b0}};
      end
   end

   // Shared multiplier, fed only from the registered operands
   float8_multiplication u_mul (
      .a      (op_a),
      .b      (op_b),
      .result (mul_s)
   );

   // Sequencer: grant in IDLE, capture the product in MUL, hold it in RESP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         rr_ptr     <= {ID_W{1'b0}};
         op_a       <= 8'd0;
         op_b       <= 8'd0;
         id_q       <= {ID_W{1'b0}};
         rsp_result <= 8'd0;
         rsp_id     <= {ID_W{1'b0}};
         rsp_valid  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_any_s) begin
                  op_a    <= sel_a_s;
                  op_b    <= sel_b_s;
                  id_q    <= grant_idx_s;
                  rr_ptr  <= next_ptr_s;
                  state_r <= ST_MUL;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_MUL: begin
               rsp_result <= mul_s;
               rsp_id     <= id_q;
               rsp_valid  <= 1'b1;
               state_r    <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_r   <= ST_IDLE;
               end else begin
                  state_r   <= ST_RESP;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
